avl_burst_responder: RTL and testbench

- Avalon-MM bursting slave: the responder end of the team's Avalon master bridges, e.g. the JTAG-to-Avalon bridge.
- Backs a word-addressed on-chip RAM, 32-bit data.
- Accepts single-beat and burst writes and reads, streams read data back with readdatavalid, and stalls the master with waitrequest during read bursts.
- Used as a bench/debug memory target and as a template for burst-capable peripherals on the Vidor fabric.

---
 rtl/avl_burst_responder.sv | 150 +++++++++++++++
 tb/tb_avl_burst_responder.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_burst_responder.sv
// Avalon-MM bursting slave over a word-addressed 32-bit RAM with pipelined read return.
// Optional macro AVL_RESP_BYTE_ENABLE_EN adds iBYTE_ENABLE for per-lane writes.
module avl_burst_responder #(
  parameter int MEM_AW       = 8,
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 16
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic [31:0] iADDRESS,
  input  logic        iWRITE,
  input  logic        iREAD,
  input  logic [31:0] iWRITE_DATA,
  input  logic [4:0]  iBURST_COUNT,
`ifdef AVL_RESP_BYTE_ENABLE_EN
  input  logic [3:0]  iBYTE_ENABLE,
`endif
  output logic        oWAIT_REQUEST,
  output logic [31:0] oREAD_DATA,
  output logic        oREAD_DATA_VALID,
  output logic        oPROTO_ERR,
  output logic [1:0]  oDEBUG_STATE
);

  // Handshake: a command is taken on an edge where the FSM is IDLE and oWAIT_REQUEST
  // was low in the preceding cycle; write beats in WR_BURST are taken whenever iWRITE=1;
  // read beats in RD_BURST are issued one per edge while oWAIT_REQUEST holds the master.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } stateT;

  stateT             state;
  logic [MEM_AW-1:0] curAddr;
  logic [4:0]        remaining;
  logic [31:0]       ram [0:(1<<MEM_AW)-1];

  logic              accept;
  logic              cmdWrite;
  logic              cmdRead;
  logic              countClamped;
  logic [4:0]        effCount;
  logic              wrEn;
  logic              rdEn;
  logic [MEM_AW-1:0] beatAddr;
  logic [3:0]        byteEn;
  logic              unusedAddrBits;

  logic [READ_LATENCY-1:0] pipeValid;
  logic [31:0]             pipeData [READ_LATENCY];

`ifdef AVL_RESP_BYTE_ENABLE_EN
  assign byteEn = iBYTE_ENABLE;
`else
  assign byteEn = 4'hF;
`endif

  assign unusedAddrBits = ^iADDRESS[31:MEM_AW];

  assign accept       = (state == IDLE) && !oWAIT_REQUEST;
  assign cmdWrite     = accept && iWRITE;
  assign cmdRead      = accept && iREAD && !iWRITE;
  assign countClamped = iBURST_COUNT > 5'(MAX_BURST);
  assign wrEn         = cmdWrite || ((state == WR_BURST) && iWRITE);
  assign rdEn         = cmdRead || (state == RD_BURST);
  assign beatAddr     = accept ? iADDRESS[MEM_AW-1:0] : curAddr;
  assign oDEBUG_STATE = state;

  always_comb begin
    effCount = iBURST_COUNT;
    if (iBURST_COUNT == 5'd0) effCount = 5'd1;
    else if (countClamped)    effCount = 5'(MAX_BURST);
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state         <= IDLE;
      oWAIT_REQUEST <= 1'b1;
      oPROTO_ERR    <= 1'b0;
      curAddr       <= '0;
      remaining     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (oWAIT_REQUEST) begin
            oWAIT_REQUEST <= 1'b0;
          end else if (iWRITE || iREAD) begin
            curAddr   <= beatAddr + MEM_AW'(1);
            remaining <= effCount - 5'd1;
            if (countClamped || (iWRITE && iREAD)) oPROTO_ERR <= 1'b1;
            if (effCount != 5'd1) begin
              if (iWRITE) begin
                state <= WR_BURST;
              end else begin
                state         <= RD_BURST;
                oWAIT_REQUEST <= 1'b1;
              end
            end
          end
        end
        WR_BURST: begin
          if (iREAD) oPROTO_ERR <= 1'b1;
          if (iWRITE) begin
            curAddr   <= curAddr + MEM_AW'(1);
            remaining <= remaining - 5'd1;
            if (remaining == 5'd1) state <= IDLE;
          end
        end
        RD_BURST: begin
          curAddr   <= curAddr + MEM_AW'(1);
          remaining <= remaining - 5'd1;
          if (remaining == 5'd1) begin
            state         <= IDLE;
            oWAIT_REQUEST <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (wrEn) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) ram[beatAddr][8*b +: 8] <= iWRITE_DATA[8*b +: 8];
      end
    end
  end

  // Reads and writes never share an edge, so a read one cycle after a write to the
  // same word already sees the committed data; data is captured at issue time.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      pipeValid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipeData[i] <= '0;
    end else begin
      pipeValid[0] <= rdEn;
      if (rdEn) pipeData[0] <= ram[beatAddr];
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeData[i]  <= pipeData[i-1];
      end
    end
  end

  assign oREAD_DATA_VALID = pipeValid[READ_LATENCY-1];
  assign oREAD_DATA       = pipeData[READ_LATENCY-1];

endmodule

// File: tb/tb_avl_burst_responder.sv
// Self-checking bench for avl_burst_responder: cycle-scheduled reference model plus
// directed literal checks and randomized burst traffic.
module tb_avl_burst_responder;

  localparam int L   = 2;
  localparam int INF = 32'h3fffffff;

  logic        iCLK = 1'b0;
  logic        iRESET;
  logic [31:0] iADDRESS;
  logic        iWRITE;
  logic        iREAD;
  logic [31:0] iWRITE_DATA;
  logic [4:0]  iBURST_COUNT;
  logic [3:0]  iBYTE_ENABLE;
  logic        oWAIT_REQUEST;
  logic [31:0] oREAD_DATA;
  logic        oREAD_DATA_VALID;
  logic        oPROTO_ERR;
  logic [1:0]  oDEBUG_STATE;

  avl_burst_responder #(.MEM_AW(8), .READ_LATENCY(L), .MAX_BURST(16)) dut (
    .iCLK             (iCLK),
    .iRESET           (iRESET),
    .iADDRESS         (iADDRESS),
    .iWRITE           (iWRITE),
    .iREAD            (iREAD),
    .iWRITE_DATA      (iWRITE_DATA),
    .iBURST_COUNT     (iBURST_COUNT),
`ifdef AVL_RESP_BYTE_ENABLE_EN
    .iBYTE_ENABLE     (iBYTE_ENABLE),
`endif
    .oWAIT_REQUEST    (oWAIT_REQUEST),
    .oREAD_DATA       (oREAD_DATA),
    .oREAD_DATA_VALID (oREAD_DATA_VALID),
    .oPROTO_ERR       (oPROTO_ERR),
    .oDEBUG_STATE     (oDEBUG_STATE)
  );

  // clock / reset
  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  // reference model state
  logic [31:0] model [256];
  logic [31:0] exp_q[$];
  int          expCyc_q[$];
  logic [31:0] seen_q[$];
  logic [31:0] wrData [16];
  int validCount  = 0;
  int waitHiCount = 0;
  int lastValidCyc = 0;
  int waitLo = INF;
  int waitHi = -1;
  int resetUntil = INF;
  int errFrom = INF;
  int nCompared = 0;
  int nMismatch = 0;
  logic expWait;
  logic expErr;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int effN(int c);
    if (c == 0) return 1;
    if (c > 16) return 16;
    return c;
  endfunction

  function automatic void modelWrite(logic [7:0] a, logic [31:0] d);
    logic [31:0] mask;
    logic [3:0]  be;
`ifdef AVL_RESP_BYTE_ENABLE_EN
    be = iBYTE_ENABLE;
`else
    be = 4'hF;
`endif
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
    model[a] = (model[a] & ~mask) | (d & mask);
  endfunction

  function automatic void noteErr();
    if (cyc + 1 < errFrom) errFrom = cyc + 1;
  endfunction

  // per-cycle compare against the model
  always @(negedge iCLK) begin
    expWait = iRESET || (cyc <= resetUntil) || (cyc >= waitLo && cyc <= waitHi);
    expErr  = !iRESET && (cyc >= errFrom);
    check("waitrequest", 32'(oWAIT_REQUEST), 32'(expWait));
    check("proto_err", 32'(oPROTO_ERR), 32'(expErr));
    if (expCyc_q.size() > 0 && expCyc_q[0] == cyc) begin
      check("read_valid", 32'(oREAD_DATA_VALID), 32'd1);
      check("read_data", oREAD_DATA, exp_q[0]);
      void'(exp_q.pop_front());
      void'(expCyc_q.pop_front());
    end else begin
      check("read_valid_idle", 32'(oREAD_DATA_VALID), 32'd0);
    end
    if (oREAD_DATA_VALID === 1'b1) begin
      seen_q.push_back(oREAD_DATA);
      validCount++;
      lastValidCyc = cyc;
    end
    if (oWAIT_REQUEST === 1'b1) waitHiCount++;
  end

  // driver tasks
  task automatic step();
    @(posedge iCLK);
    #2;
  endtask

  task automatic writeBurst(input logic [31:0] addr, input int cnt, input int stallAfter,
                            input int stallLen, input bit withRead, input bit readInStall);
    int n;
    n = effN(cnt);
    for (int k = 0; k < n; k++) begin
      iWRITE       = 1'b1;
      iREAD        = (k == 0) && withRead;
      iADDRESS     = addr;
      iBURST_COUNT = 5'(cnt);
      iWRITE_DATA  = wrData[k];
      modelWrite(addr[7:0] + 8'(k), wrData[k]);
      if (k == 0 && (cnt > 16 || withRead)) noteErr();
      step();
      if (k == stallAfter && k < n - 1) begin
        for (int s = 0; s < stallLen; s++) begin
          iWRITE = 1'b0;
          iREAD  = readInStall;
          if (readInStall) noteErr();
          step();
        end
      end
    end
    iWRITE = 1'b0;
    iREAD  = 1'b0;
  endtask

  task automatic readBurst(input logic [31:0] addr, input int cnt, input int maxSteps);
    int n;
    int c;
    n = effN(cnt);
    c = cyc;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model[addr[7:0] + 8'(k)]);
      expCyc_q.push_back(c + k + L);
    end
    if (n > 1) begin
      waitLo = c + 1;
      waitHi = c + n - 1;
    end
    if (cnt > 16) noteErr();
    iREAD        = 1'b1;
    iWRITE       = 1'b0;
    iADDRESS     = addr;
    iBURST_COUNT = 5'(cnt);
    step();
    iREAD = 1'b0;
    repeat ((n - 1 < maxSteps) ? n - 1 : maxSteps) step();
  endtask

  task automatic doReset(input int hold);
    iRESET = 1'b1;
    iREAD  = 1'b0;
    iWRITE = 1'b0;
    exp_q.delete();
    expCyc_q.delete();
    waitLo     = INF;
    waitHi     = -1;
    errFrom    = INF;
    resetUntil = INF;
    repeat (hold) step();
    iRESET     = 1'b0;
    resetUntil = cyc;
    step();
  endtask

  task automatic fillRandom();
    for (int k = 0; k < 16; k++) wrData[k] = $urandom;
  endtask

  // stimulus
  int vc;
  int wh;
  int n;
  initial begin
    iRESET = 1'b1; iADDRESS = '0; iWRITE = 1'b0; iREAD = 1'b0;
    iWRITE_DATA = '0; iBURST_COUNT = '0; iBYTE_ENABLE = 4'hF;

    repeat (3) step();
    check("reset_read_data", oREAD_DATA, 32'h0);
    check("reset_wait", 32'(oWAIT_REQUEST), 32'd1);
    iRESET = 1'b0;
    resetUntil = cyc;
    #1;
    check("wait_at_release", 32'(oWAIT_REQUEST), 32'd1);
    step();
    check("wait_after_first_edge", 32'(oWAIT_REQUEST), 32'd0);

    for (int b = 0; b < 16; b++) begin
      fillRandom();
      writeBurst(32'(b * 16), 16, -1, 0, 1'b0, 1'b0);
    end

    // single write then immediate read of the same word
    wrData[0] = 32'hDEADBEEF;
    writeBurst(32'h10, 1, -1, 0, 1'b0, 1'b0);
    vc = validCount;
    wh = cyc + 1;
    readBurst(32'h10, 1, 99);
    repeat (L + 1) step();
    check("single_count", 32'(validCount - vc), 32'd1);
    check("single_data", seen_q[seen_q.size()-1], 32'hDEADBEEF);
    check("single_latency", 32'(lastValidCyc - wh), 32'(L - 1));

    // write burst with a master stall, then read burst
    wrData[0] = 32'h11; wrData[1] = 32'h22; wrData[2] = 32'h33; wrData[3] = 32'h44;
    writeBurst(32'h20, 4, 1, 2, 1'b0, 1'b0);
    vc = validCount;
    wh = waitHiCount;
    readBurst(32'h20, 4, 99);
    repeat (L + 1) step();
    check("burst4_count", 32'(validCount - vc), 32'd4);
    check("burst4_beat0", seen_q[seen_q.size()-4], 32'h11);
    check("burst4_beat1", seen_q[seen_q.size()-3], 32'h22);
    check("burst4_beat2", seen_q[seen_q.size()-2], 32'h33);
    check("burst4_beat3", seen_q[seen_q.size()-1], 32'h44);
    check("burst4_wait_cycles", 32'(waitHiCount - wh), 32'd3);

    // address wrap at the top of the RAM
    wrData[0] = 32'hA1A1A1A1; wrData[1] = 32'hB2B2B2B2; wrData[2] = 32'hC3C3C3C3;
    writeBurst(32'hFE, 3, -1, 0, 1'b0, 1'b0);
    readBurst(32'hFE, 3, 99);
    readBurst(32'h00, 1, 99);
    repeat (L + 1) step();
    check("wrap_fe", seen_q[seen_q.size()-4], 32'hA1A1A1A1);
    check("wrap_ff", seen_q[seen_q.size()-3], 32'hB2B2B2B2);
    check("wrap_00", seen_q[seen_q.size()-2], 32'hC3C3C3C3);
    check("wrap_00_single", seen_q[seen_q.size()-1], 32'hC3C3C3C3);

    // burst-count edge cases
    vc = validCount;
    readBurst(32'h40, 0, 99);
    repeat (L + 1) step();
    check("count0_beats", 32'(validCount - vc), 32'd1);
    check("count0_no_err", 32'(oPROTO_ERR), 32'd0);
    vc = validCount;
    readBurst(32'h40, 20, 99);
    repeat (L + 1) step();
    check("count20_beats", 32'(validCount - vc), 32'd16);
    check("count20_err", 32'(oPROTO_ERR), 32'd1);

    // read and write together in IDLE
    doReset(2);
    check("err_cleared", 32'(oPROTO_ERR), 32'd0);
    wrData[0] = 32'hCAFEF00D;
    writeBurst(32'h50, 1, -1, 0, 1'b1, 1'b0);
    check("both_high_err", 32'(oPROTO_ERR), 32'd1);
    readBurst(32'h50, 1, 99);
    repeat (L + 1) step();
    check("both_high_write_done", seen_q[seen_q.size()-1], 32'hCAFEF00D);

    // read during a write-burst stall
    doReset(1);
    fillRandom();
    writeBurst(32'h60, 4, 0, 1, 1'b0, 1'b1);
    check("read_in_wrburst_err", 32'(oPROTO_ERR), 32'd1);

    // reset in the middle of a read burst
    doReset(1);
    readBurst(32'h00, 8, 2);
    doReset(1);
    vc = validCount;
    repeat (10) step();
    check("midburst_no_valid", 32'(validCount - vc), 32'd0);
    readBurst(32'h20, 1, 99);
    repeat (L + 1) step();
    check("after_reset_read", seen_q[seen_q.size()-1], 32'h11);

    // write immediately following a read burst must not disturb in-flight beats
    readBurst(32'h20, 2, 99);
    wrData[0] = 32'h99999999;
    writeBurst(32'h21, 1, -1, 0, 1'b0, 1'b0);
    repeat (L + 1) step();
    check("inflight_beat_kept", seen_q[seen_q.size()-1], 32'h22);

`ifdef AVL_RESP_BYTE_ENABLE_EN
    wrData[0] = 32'hFFFFFFFF;
    writeBurst(32'h70, 1, -1, 0, 1'b0, 1'b0);
    iBYTE_ENABLE = 4'b0101;
    wrData[0] = 32'h00000000;
    writeBurst(32'h70, 1, -1, 0, 1'b0, 1'b0);
    iBYTE_ENABLE = 4'hF;
    readBurst(32'h70, 1, 99);
    repeat (L + 1) step();
    check("byte_enable_merge", seen_q[seen_q.size()-1], 32'hFF00FF00);
`endif

    // randomized traffic
    repeat (80) begin
      int op;
      logic [31:0] addr;
      int cnt;
      op   = $urandom_range(0, 19);
      addr = $urandom;
      cnt  = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
      fillRandom();
      if (op < 8) begin
        writeBurst(addr, cnt, $urandom_range(0, 15), $urandom_range(0, 3), 1'b0,
                   $urandom_range(0, 7) == 0);
      end else if (op < 17) begin
        readBurst(addr, cnt, 99);
      end else if (op < 19) begin
        writeBurst(addr, cnt, -1, 0, 1'b1, 1'b0);
      end else begin
        doReset($urandom_range(1, 3));
      end
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (L + 3) step();
    n = exp_q.size();
    check("queue_drained", 32'(n), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  initial begin
    #300000;
    nMismatch++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
